// File: rtl/ring_phase_pkg.sv
// Shared state encodings and widths for the ring phase driver and its dead-time timer.
package ring_phase_pkg;

    localparam int RING_W  = 4;
    localparam int TIMER_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DEAD  = 2'b01,
        ST_DRIVE = 2'b10,
        ST_FAULT = 2'b11
    } ring_state_e;

    typedef logic [RING_W-1:0] ring_vec_t;

endpackage

// File: rtl/ring_dead_time_timer.sv
// Loadable down-counter that flags the last dead-time clock before a phase is driven.
module ring_dead_time_timer
    import ring_phase_pkg::*;
(
    input  logic               Clk_In,
    input  logic               Reset_N_In,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               decrement,
    output logic               expire
);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (decrement && (count_q != '0)) begin
            count_q <= count_q - TIMER_W'(1);
        end
    end

    // Expiry is seen on the clock whose edge leaves DEAD, so the zero gap is exactly the load value.
    assign expire = (count_q == TIMER_W'(1));

endmodule

// File: rtl/ring_phase_driver.sv
// Converts a one-hot upstream ring count into non-overlapping phase drives with dead time,
// rotation counting and a sticky fault for skipped, reversed or malformed ring states.
module ring_phase_driver
    import ring_phase_pkg::*;
#(
    parameter int DEAD_TIME_CYCLES = 2,
    parameter int ROT_COUNT_WIDTH  = 8
) (
    input  logic                       Clk_In,
    input  logic                       Reset_N_In,
    input  logic                       Enable_In,
    input  logic [RING_W-1:0]          Ring_Count_In,
    input  logic                       Ring_Running_In,
    input  logic                       Fault_Clear_In,
    output logic [RING_W-1:0]          Phase_Out,
    output logic                       Dead_Time_Active_Out,
    output logic [ROT_COUNT_WIDTH-1:0] Rotation_Count_Out,
    output logic                       Fault_Flag_Out
);

    ring_state_e                state_q, state_d;
    ring_vec_t                  target_q, target_d;
    ring_vec_t                  phase_q;
    logic [ROT_COUNT_WIDTH-1:0] rot_q;
    logic                       fault_q;

    logic      ring_valid;
    logic      is_hold;
    logic      is_next;
    logic      is_wrap;
    ring_vec_t next_phase;
    logic      tmr_load;
    logic      tmr_dec;
    logic      tmr_expire;
    logic      rot_inc;

    function automatic logic one_hot(input ring_vec_t v);
        return (v != '0) && ((v & (v - RING_W'(1))) == '0);
    endfunction

    assign ring_valid = one_hot(Ring_Count_In);
    assign next_phase = {target_q[RING_W-2:0], target_q[RING_W-1]};
    assign is_hold    = (Ring_Count_In == target_q);
    assign is_next    = (Ring_Count_In == next_phase);
    assign is_wrap    = (target_q == 4'b1000) && (Ring_Count_In == 4'b0001);

    ring_dead_time_timer u_timer (
        .Clk_In     (Clk_In),
        .Reset_N_In (Reset_N_In),
        .load       (tmr_load),
        .load_value (TIMER_W'(DEAD_TIME_CYCLES)),
        .decrement  (tmr_dec),
        .expire     (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        rot_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Ring_Running_In) begin
                    if (!ring_valid) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d  = ST_DEAD;
                        target_d = Ring_Count_In;
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_DEAD, ST_DRIVE: begin
                if (!Ring_Running_In) begin
                    state_d = ST_IDLE;
                end else if (!ring_valid) begin
                    state_d = ST_FAULT;
                end else if (is_hold) begin
                    if (state_q == ST_DEAD) begin
                        tmr_dec = 1'b1;
                        if (tmr_expire) begin
                            state_d = ST_DRIVE;
                        end
                    end
                end else if (is_next) begin
                    // A step forward always restarts the dead gap, even mid-gap.
                    state_d  = ST_DEAD;
                    target_d = Ring_Count_In;
                    tmr_load = 1'b1;
                    rot_inc  = is_wrap;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (Ring_Running_In && !ring_valid) begin
                    state_d = ST_FAULT;
                end else if (Fault_Clear_In) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            phase_q  <= '0;
            rot_q    <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            phase_q  <= (state_d == ST_DRIVE) ? target_d : '0;
            fault_q  <= (state_d == ST_FAULT);
            if (rot_inc) begin
                rot_q <= rot_q + ROT_COUNT_WIDTH'(1);
            end
        end
    end

    // Disabling only floats the pins; the FSM and counters keep tracking the ring.
    assign Phase_Out            = Enable_In ? phase_q : {RING_W{1'bz}};
    assign Dead_Time_Active_Out = Enable_In ? (state_q == ST_DEAD) : 1'bz;
    assign Rotation_Count_Out   = Enable_In ? rot_q : {ROT_COUNT_WIDTH{1'bz}};
    assign Fault_Flag_Out       = Enable_In ? fault_q : 1'bz;

endmodule
